// File: rtl/ir_byte_fetch.sv
// Fetch sequencer: reads 1-4 bytes over a req/valid handshake and assembles
// them big-endian into a downstream 32-bit register via its I/FunSel/E inputs.
module ir_byte_fetch #(
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        NumBytes,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              Abort,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [7:0]        MemData,
  input  logic              MemValid,
  output logic [31:0]       RegI,
  output logic [2:0]        RegFunSel,
  output logic              RegE,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {IDLE, REQ, LOAD, DONE} state_t;

  localparam logic [2:0] FS_CLR_LOAD   = 3'b100;
  localparam logic [2:0] FS_SHIFT_LOAD = 3'b110;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [7:0]          byte_q, byte_d;
  logic [2:0]          fs_q, fs_d;
  logic                rege_q, rege_d;
  logic                done_q, done_d;
  logic [1:0]          remain_q, remain_d;
  logic                first_q, first_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    byte_d   = byte_q;
    fs_d     = fs_q;
    rege_d   = 1'b0;
    done_d   = 1'b0;
    remain_d = remain_q;
    first_d  = first_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          addr_d   = BaseAddr;
          remain_d = NumBytes;
          first_d  = 1'b1;
          rd_d     = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Abort outranks a coincident MemValid: the returned byte is dropped.
        if (Abort) begin
          rd_d    = 1'b0;
          state_d = IDLE;
        end else if (MemValid) begin
          byte_d  = MemData;
          fs_d    = first_q ? FS_CLR_LOAD : FS_SHIFT_LOAD;
          rd_d    = 1'b0;
          rege_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        first_d = 1'b0;
        if (Abort) begin
          rd_d    = 1'b0;
          state_d = IDLE;
        end else if (remain_q == 2'd0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          remain_d = remain_q - 2'd1;
          addr_d   = addr_q + ADDR_W'(1);
          rd_d     = 1'b1;
          state_d  = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      byte_q   <= '0;
      fs_q     <= 3'b000;
      rege_q   <= 1'b0;
      done_q   <= 1'b0;
      remain_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      byte_q   <= byte_d;
      fs_q     <= fs_d;
      rege_q   <= rege_d;
      done_q   <= done_d;
      remain_q <= remain_d;
      first_q  <= first_d;
    end
  end

  assign MemAddr   = addr_q;
  assign MemRd     = rd_q;
  assign RegI      = {24'b0, byte_q};
  assign RegFunSel = fs_q;
  assign RegE      = rege_q;
  assign Done      = done_q;
  assign Busy      = (state_q == REQ) || (state_q == LOAD);

endmodule

// File: tb/tb_ir_byte_fetch.sv
// Randomized bench for ir_byte_fetch: memory responder, downstream register
// model and a byte-sequence reference model computed from the fetch rules.
module tb_ir_byte_fetch;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  NumBytes = '0;
  logic [15:0] BaseAddr = '0;
  logic        Abort = 1'b0;
  logic [15:0] MemAddr;
  logic        MemRd;
  logic [7:0]  MemData = '0;
  logic        MemValid = 1'b0;
  logic [31:0] RegI;
  logic [2:0]  RegFunSel;
  logic        RegE;
  logic        Busy;
  logic        Done;

  ir_byte_fetch #(.ADDR_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .NumBytes(NumBytes),
    .BaseAddr(BaseAddr), .Abort(Abort), .MemAddr(MemAddr), .MemRd(MemRd),
    .MemData(MemData), .MemValid(MemValid), .RegI(RegI),
    .RegFunSel(RegFunSel), .RegE(RegE), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [2:0]  fs;
  } ev_t;

  ev_t         ev_q[$];
  logic [7:0]  mem [0:65535];
  logic [31:0] dreg = '0;
  int lat_cfg = 0, abort_k = -1, ret_idx = 0, wait_cnt = 0;
  bit noise = 1'b0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, ri_err = 0;
  int n_cycles, latency, busy_after, stab_err, timed_out;
  int tests = 0, fails = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // Downstream register model, event log and memory responder.
  always @(negedge Clock) begin
    if (RegE === 1'b1) begin
      ev_q.push_back('{addr: MemAddr, data: RegI[7:0], fs: RegFunSel});
      if (RegI[31:8] !== 24'h0) ri_err++;
      if (RegFunSel === 3'b100)      dreg = {24'h0, RegI[7:0]};
      else if (RegFunSel === 3'b110) dreg = {dreg[23:0], RegI[7:0]};
    end
    if (Done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (MemRd === 1'b1) begin
      if (wait_cnt >= lat_cfg) begin
        MemValid = 1'b1;
        MemData  = mem[MemAddr];
        Abort    = (ret_idx == abort_k);
        ret_idx++;
        wait_cnt = 0;
      end else begin
        MemValid = 1'b0;
        Abort    = 1'b0;
        wait_cnt++;
      end
    end else begin
      MemValid = noise ? 1'($urandom) : 1'b0;
      MemData  = 8'($urandom);
      Abort    = 1'b0;
      wait_cnt = 0;
    end
  end

  // Expected downstream value after n bytes fetched big-endian from base.
  function automatic logic [31:0] model_value(input logic [15:0] base, input int n,
                                              input logic [31:0] prev);
    logic [31:0] v;
    logic [15:0] a;
    if (n == 0) return prev;
    v = '0;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      v = (v << 8) | {24'h0, mem[a]};
    end
    return v;
  endfunction

  task automatic run_fetch(input logic [15:0] base, input logic [1:0] nb, input int lat,
                           input int ak, input bit nz, input bit spur);
    logic prd, pval;
    logic [15:0] paddr;
    int t0;
    lat_cfg = lat; abort_k = ak; noise = nz; ret_idx = 0;
    @(negedge Clock); #1;
    ev_q.delete(); done_cnt = 0; done_cyc = -1; stab_err = 0; timed_out = 0; ri_err = 0;
    BaseAddr = base; NumBytes = nb; Start = 1'b1; t0 = cyc;
    @(negedge Clock); #1;
    Start = 1'b0;
    prd = 1'b0; pval = 1'b0; paddr = '0; n_cycles = 0;
    while (Busy === 1'b1) begin
      if (n_cycles > 200) begin timed_out = 1; break; end
      if (prd && !pval && (MemRd !== 1'b1 || MemAddr !== paddr)) stab_err++;
      prd = MemRd; pval = MemValid; paddr = MemAddr;
      if (spur && n_cycles < 2) begin
        Start = 1'b1; BaseAddr = base ^ 16'h00F0; NumBytes = ~nb;
      end else Start = 1'b0;
      @(negedge Clock); #1;
      n_cycles++;
    end
    if (spur && Done === 1'b1) begin
      Start = 1'b1; BaseAddr = base + 16'd3; NumBytes = 2'd3;
    end
    @(negedge Clock); #1;
    Start = 1'b0;
    busy_after = int'(Busy === 1'b1);
    @(negedge Clock); #1;
    busy_after = busy_after | int'(Busy === 1'b1);
    latency = (done_cyc >= 0) ? done_cyc - t0 : -1;
    tests++;
    if (timed_out != 0) begin
      fails++;
      $display("FAIL fetch_timeout: still busy after %0d cycles, required idle", n_cycles);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    tests++;
    if ({MemAddr, MemRd, RegI, RegFunSel, RegE, Done, Busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: addr=%h rd=%b i=%h fs=%b e=%b done=%b busy=%b, required all 0",
               MemAddr, MemRd, RegI, RegFunSel, RegE, Done, Busy);
    end
    Reset = 1'b1;
  endtask

  task automatic test_deadbeef();
    int err = 0;
    mem[16'h1000] = 8'hDE; mem[16'h1001] = 8'hAD; mem[16'h1002] = 8'hBE; mem[16'h1003] = 8'hEF;
    run_fetch(16'h1000, 2'b11, 0, -1, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 4) begin
      fails++; $display("FAIL deadbeef_rege_count: got %0d, required 4", ev_q.size());
    end else begin
      foreach (ev_q[i]) if (ev_q[i].fs !== ((i == 0) ? 3'b100 : 3'b110)) err++;
      tests++;
      if (err != 0) begin
        fails++; $display("FAIL deadbeef_funsel: %0d wrong FunSel values, required 100,110,110,110", err);
      end
    end
    tests++;
    if (dreg !== 32'hDEADBEEF) begin
      fails++; $display("FAIL deadbeef_value: got %h, required deadbeef", dreg);
    end
    tests++;
    if (latency != 9 || done_cnt != 1) begin
      fails++; $display("FAIL deadbeef_done: latency %0d count %0d, required 9 and 1", latency, done_cnt);
    end
    tests++;
    if (busy_after != 0) begin
      fails++; $display("FAIL deadbeef_busy_after: got %0d, required 0", busy_after);
    end
  endtask

  task automatic test_single_byte();
    logic [15:0] base = 16'($urandom);
    mem[base] = 8'h7F;
    @(negedge Clock); dreg = 32'hFFFF_FFFF;
    run_fetch(base, 2'b00, 0, -1, 1'b1, 1'b0);
    tests++;
    if (ev_q.size() != 1 || ev_q[0].fs !== 3'b100) begin
      fails++; $display("FAIL single_rege: count %0d, required 1 with FunSel 100", ev_q.size());
    end
    tests++;
    if (dreg !== 32'h0000_007F) begin
      fails++; $display("FAIL single_value: got %h, required 0000007f", dreg);
    end
    tests++;
    if (latency != 3) begin
      fails++; $display("FAIL single_latency: got %0d, required 3", latency);
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] base = 16'h2340;
    mem[base] = 8'h12; mem[base + 16'd1] = 8'h34;
    run_fetch(base, 2'b01, 3, -1, 1'b0, 1'b0);
    tests++;
    if (stab_err != 0) begin
      fails++; $display("FAIL wait_stability: %0d unstable cycles, required 0", stab_err);
    end
    tests++;
    if (ev_q.size() != 2 || dreg !== 32'h0000_1234) begin
      fails++; $display("FAIL wait_value: count %0d value %h, required 2 and 00001234", ev_q.size(), dreg);
    end
    tests++;
    if (latency != 11) begin
      fails++; $display("FAIL wait_latency: got %0d, required 11", latency);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'hA5; mem[16'h0000] = 8'h5A;
    run_fetch(16'hFFFF, 2'b01, 1, -1, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 2 || ev_q[0].addr !== 16'hFFFF || ev_q[1].addr !== 16'h0000) begin
      fails++; $display("FAIL wrap_addr: count %0d second addr %h, required 2 and 0000",
                        ev_q.size(), (ev_q.size() > 1) ? ev_q[1].addr : 16'hxxxx);
    end
    tests++;
    if (dreg !== 32'h0000_A55A) begin
      fails++; $display("FAIL wrap_value: got %h, required 0000a55a", dreg);
    end
  endtask

  task automatic test_abort();
    logic [15:0] base = 16'($urandom);
    logic [31:0] exp;
    run_fetch(base, 2'b11, 0, 1, 1'b0, 1'b0);
    tests++;
    if (ev_q.size() != 1 || done_cnt != 0) begin
      fails++; $display("FAIL abort_effect: rege %0d done %0d, required 1 and 0", ev_q.size(), done_cnt);
    end
    tests++;
    if (n_cycles != 3 || dreg !== {24'h0, mem[base]}) begin
      fails++; $display("FAIL abort_idle: busy cycles %0d value %h, required 3 and %h",
                        n_cycles, dreg, {24'h0, mem[base]});
    end
    base = 16'($urandom);
    exp = model_value(base, 3, dreg);
    run_fetch(base, 2'b10, 0, -1, 1'b0, 1'b0);
    tests++;
    if (dreg !== exp || done_cnt != 1) begin
      fails++; $display("FAIL abort_restart: value %h done %0d, required %h and 1", dreg, done_cnt, exp);
    end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] base = 16'($urandom);
    logic [31:0] exp = model_value(base, 2, dreg);
    run_fetch(base, 2'b01, 1, -1, 1'b0, 1'b1);
    tests++;
    if (ev_q.size() != 2 || ev_q[0].addr !== base || ev_q[1].addr !== base + 16'd1) begin
      fails++; $display("FAIL busy_start_addr: count %0d, required 2 bytes from %h", ev_q.size(), base);
    end
    tests++;
    if (dreg !== exp || done_cnt != 1 || busy_after != 0) begin
      fails++; $display("FAIL busy_start_result: value %h done %0d busy %0d, required %h, 1, 0",
                        dreg, done_cnt, busy_after, exp);
    end
  endtask

  task automatic test_reset_midfetch();
    int guard = 0;
    lat_cfg = 2; abort_k = -1; noise = 1'b0; ret_idx = 0;
    @(negedge Clock); #1;
    ev_q.delete(); done_cnt = 0;
    BaseAddr = 16'($urandom); NumBytes = 2'b11; Start = 1'b1;
    @(negedge Clock); #1;
    Start = 1'b0;
    while (!(ev_q.size() == 2 && MemRd === 1'b1) && guard < 100) begin
      @(negedge Clock); #1;
      guard++;
    end
    tests++;
    if (guard >= 100) begin
      fails++; $display("FAIL rst_mid_reach: third request not seen, rege %0d, required 2", ev_q.size());
    end
    Reset = 1'b0;
    @(negedge Clock); #1;
    tests++;
    if ({MemAddr, MemRd, RegI, RegFunSel, RegE, Done, Busy} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: addr=%h rd=%b busy=%b e=%b, required all 0",
                        MemAddr, MemRd, Busy, RegE);
    end
    Reset = 1'b1;
    repeat (10) @(negedge Clock);
    #1;
    tests++;
    if (ev_q.size() != 2 || done_cnt != 0 || Busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_quiet: rege %0d done %0d busy %b, required 2, 0, 0",
                        ev_q.size(), done_cnt, Busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [15:0] base = 16'($urandom);
      logic [1:0]  nb   = 2'($urandom);
      int lat = $urandom_range(0, 3);
      int ak  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(nb)) : -1;
      int n_exp = (ak >= 0) ? ak : int'(nb) + 1;
      logic [31:0] exp = model_value(base, n_exp, dreg);
      int err = 0;
      run_fetch(base, nb, lat, ak, 1'($urandom), 1'b0);
      foreach (ev_q[i]) begin
        if (ev_q[i].addr !== base + 16'(i) || ev_q[i].data !== mem[base + 16'(i)] ||
            ev_q[i].fs !== ((i == 0) ? 3'b100 : 3'b110)) err++;
      end
      tests++;
      if (ev_q.size() != n_exp || err != 0 || ri_err != 0) begin
        fails++; $display("FAIL rand%0d_bytes: count %0d bad %0d, required %0d and 0",
                          it, ev_q.size(), err + ri_err, n_exp);
      end
      tests++;
      if (dreg !== exp) begin
        fails++; $display("FAIL rand%0d_value: got %h, required %h", it, dreg, exp);
      end
      tests++;
      if (done_cnt != ((ak >= 0) ? 0 : 1) || stab_err != 0 || busy_after != 0) begin
        fails++; $display("FAIL rand%0d_ctrl: done %0d stab %0d busy %0d, required %0d, 0, 0",
                          it, done_cnt, stab_err, busy_after, (ak >= 0) ? 0 : 1);
      end
      if (ak < 0) begin
        tests++;
        if (latency != 1 + n_exp * (2 + lat)) begin
          fails++; $display("FAIL rand%0d_latency: got %0d, required %0d", it, latency, 1 + n_exp * (2 + lat));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_deadbeef();
    test_single_byte();
    test_wait_states();
    test_wrap();
    test_abort();
    test_start_while_busy();
    test_reset_midfetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
